pot_scan_ctrl: RTL and testbench



---
 rtl/eq_pkg.sv | 12 +
 rtl/pot_scan_ctrl_if.sv | 13 +
 rtl/pot_scan_ctrl.sv | 112 +++++++++++
 tb/tb_pot_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer pot scanner and EQ engine.
package eq_pkg;

  typedef enum logic [1:0] {GAP, START, WAIT} scan_state_t;

  localparam int NUM_POTS = 6;
  localparam int POT_W    = 12;

  // Slot order LP, B1, B2, B3, HP, VOL mapped to A2D channel numbers.
  localparam logic [2:0] CH_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

endpackage

// File: rtl/pot_scan_ctrl_if.sv
// Start/complete handshake between the pot scanner and the A2D converter.
interface pot_scan_ctrl_if;
  import eq_pkg::*;

  logic             strt_cnv;
  logic [2:0]       chnnl;
  logic             cnv_cmplt;
  logic [POT_W-1:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);

endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin A2D scheduler for the six EQ pots, with per-conversion timeout
// and bounded retry so a dead converter cannot stall the scan.
module pot_scan_ctrl
  import eq_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pot_scan_ctrl_if.master  a2d,
  output logic [POT_W-1:0] POT_LP,
  output logic [POT_W-1:0] POT_B1,
  output logic [POT_W-1:0] POT_B2,
  output logic [POT_W-1:0] POT_B3,
  output logic [POT_W-1:0] POT_HP,
  output logic [POT_W-1:0] POT_VOL,
  output logic             scan_done,
  output logic             a2d_err
);

  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [2:0]       LAST_SLOT = 3'(NUM_POTS - 1);

  scan_state_t      state, state_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] rty_cnt;
  logic [2:0]       slot, slot_nx;
  logic [2:0]       chnnl_q;
  logic [POT_W-1:0] pot_q [NUM_POTS];
  logic             capture, advance, skip, retry;

  assign slot_nx      = (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
  assign a2d.strt_cnv = (state == START);
  assign a2d.chnnl    = chnnl_q;

  assign POT_LP  = pot_q[0];
  assign POT_B1  = pot_q[1];
  assign POT_B2  = pot_q[2];
  assign POT_B3  = pot_q[3];
  assign POT_HP  = pot_q[4];
  assign POT_VOL = pot_q[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GAP;
    else        state <= state_nx;
  end

  // A completion on the final timeout cycle takes priority over the timeout.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    advance  = 1'b0;
    skip     = 1'b0;
    retry    = 1'b0;
    case (state)
      GAP:   if (gap_cnt == GAP_LAST) state_nx = START;
      START: state_nx = WAIT;
      WAIT: begin
        if (a2d.cnv_cmplt) begin
          capture  = 1'b1;
          advance  = 1'b1;
          state_nx = GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          if (rty_cnt == RTY_MAX) begin
            skip     = 1'b1;
            advance  = 1'b1;
            state_nx = GAP;
          end else begin
            retry    = 1'b1;
            state_nx = START;
          end
        end
      end
      default: state_nx = GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      rty_cnt   <= '0;
      slot      <= 3'd0;
      chnnl_q   <= CH_MAP[0];
      scan_done <= 1'b0;
      a2d_err   <= 1'b0;
      for (int i = 0; i < NUM_POTS; i++) pot_q[i] <= '0;
    end else begin
      gap_cnt   <= (state == GAP && state_nx == GAP) ? gap_cnt + 1'b1 : '0;
      tmo_cnt   <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
      scan_done <= advance && (slot == LAST_SLOT);
      if (retry)        rty_cnt <= rty_cnt + 1'b1;
      else if (advance) rty_cnt <= '0;
      if (advance) begin
        slot    <= slot_nx;
        chnnl_q <= CH_MAP[slot_nx];
      end
      if (skip)    a2d_err     <= 1'b1;
      if (capture) pot_q[slot] <= a2d.res;
    end
  end

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Bench for pot_scan_ctrl: an event-level model of the scan schedule predicts
// every strt_cnv cycle, channel, scan_done pulse, error flag and pot value.
module tb_pot_scan_ctrl;

  localparam int GAP = 16;
  localparam int TMO = 64;
  localparam int MR  = 2;

  typedef struct {
    logic [5:0]  silent;
    int          dly;
    logic [11:0] base;
    bit          inc;
    bit          stray;
    logic [71:0] pots;
    bit          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pot_scan_ctrl_if bus ();
  logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol;
  logic        scan_done, a2d_err;

  pot_scan_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .a2d(bus),
    .POT_LP(pot_lp), .POT_B1(pot_b1), .POT_B2(pot_b2), .POT_B3(pot_b3),
    .POT_HP(pot_hp), .POT_VOL(pot_vol), .scan_done(scan_done), .a2d_err(a2d_err)
  );

  int          ch_tab [6] = '{1, 0, 4, 2, 3, 7};
  int          cyc = 0, nvec = 0, nbad = 0;
  logic [11:0] m_pot [6];
  logic        m_err;
  logic [2:0]  m_ch, ch_nx;
  int          m_slot, attempts, sweeps = 0;
  int          exp_strt, cnv_at, stray_at, done_at, err_at, ch_at;
  vec_t        cfg;
  bit          rnd = 1'b0;
  vec_t        tbl [6];

  function automatic logic [71:0] dut_pots();
    return {pot_vol, pot_hp, pot_b3, pot_b2, pot_b1, pot_lp};
  endfunction

  function automatic logic [71:0] mdl_pots();
    return {m_pot[5], m_pot[4], m_pot[3], m_pot[2], m_pot[1], m_pot[0]};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_pot[i] = 12'h000;
    m_err = 1'b0; m_ch = 3'd1; m_slot = 0; attempts = 0;
    exp_strt = -1; cnv_at = -1; stray_at = -1; done_at = -1; err_at = -1; ch_at = -1;
  endtask

  // Slot finishes (stored or skipped); effects become visible at cycle t.
  task automatic slot_done(input int t);
    if (m_slot == 5) begin
      done_at = t;
      sweeps++;
    end
    m_slot = (m_slot + 1) % 6;
    ch_at  = t;
    ch_nx  = 3'(ch_tab[m_slot]);
  endtask

  task automatic step();
    logic [11:0] r;
    bit          sil;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == err_at) m_err = 1'b1;
    if (cyc == ch_at)  m_ch  = ch_nx;
    chk("strt_cnv", 72'(bus.strt_cnv), 72'(cyc == exp_strt));
    chk("chnnl", 72'(bus.chnnl), 72'(m_ch));
    chk("scan_done", 72'(scan_done), 72'(cyc == done_at));
    chk("a2d_err", 72'(a2d_err), 72'(m_err));
    chk("pots", dut_pots(), mdl_pots());
    bus.cnv_cmplt = 1'b0;
    bus.res       = 12'($urandom);
    if (bus.strt_cnv && rst_n) begin
      sil = cfg.silent[m_slot] || (rnd && $urandom_range(0, 3) == 0);
      if (sil) begin
        attempts++;
        if (attempts > MR) begin
          attempts = 0;
          err_at   = cyc + TMO + 1;
          exp_strt = cyc + TMO + 1 + GAP;
          slot_done(cyc + TMO + 1);
        end else begin
          exp_strt = cyc + TMO + 1;
        end
      end else begin
        cnv_at   = cyc + (rnd ? $urandom_range(1, TMO) : cfg.dly);
        exp_strt = cnv_at + 1 + GAP;
      end
    end
    if (cyc == cnv_at) begin
      r = rnd ? 12'($urandom) : cfg.base + (cfg.inc ? 12'(m_slot) : 12'd0);
      bus.cnv_cmplt = 1'b1;
      bus.res       = r;
      m_pot[m_slot] = r;
      attempts      = 0;
      slot_done(cyc + 1);
      if (cfg.stray) stray_at = cyc + 1 + $urandom_range(0, GAP - 1);
    end else if (cyc == stray_at) begin
      bus.cnv_cmplt = 1'b1;
      bus.res       = 12'hFFF;
    end
  endtask

  task automatic run_sweeps(input int k);
    int target, lim;
    target = sweeps + k;
    lim    = cyc + 3000;
    while ((sweeps < target || cyc < done_at) && cyc < lim) step();
    if (cyc >= lim) begin
      nvec++; nbad++;
      $display("FAIL sweep_timeout at cycle %0d: sweeps %0d required %0d", cyc, sweeps, target);
    end
  endtask

  initial begin
    tbl[0] = '{6'b000000, 5,   12'h100, 1'b1, 1'b0,
               {12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}, 1'b0};
    tbl[1] = '{6'b000000, 5,   12'h200, 1'b1, 1'b1,
               {12'h205, 12'h204, 12'h203, 12'h202, 12'h201, 12'h200}, 1'b0};
    tbl[2] = '{6'b000100, 5,   12'h300, 1'b1, 1'b0,
               {12'h305, 12'h304, 12'h303, 12'h202, 12'h301, 12'h300}, 1'b1};
    tbl[3] = '{6'b000000, TMO, 12'hABC, 1'b0, 1'b0, {6{12'hABC}}, 1'b1};
    tbl[4] = '{6'b000000, 5,   12'hFFF, 1'b0, 1'b1, {6{12'hFFF}}, 1'b1};
    tbl[5] = '{6'b000000, 7,   12'h000, 1'b0, 1'b1, {6{12'h000}}, 1'b1};

    rst_n = 1'b0;
    bus.cnv_cmplt = 1'b0;
    bus.res = 12'h000;
    model_reset();
    cfg = tbl[0];
    step();
    step();
    rst_n = 1'b1;
    exp_strt = cyc + GAP;

    for (int i = 0; i < 6; i++) begin
      cfg = tbl[i];
      run_sweeps(1);
      chk($sformatf("tbl%0d_pots", i), dut_pots(), tbl[i].pots);
      chk($sformatf("tbl%0d_err", i), 72'(a2d_err), 72'(tbl[i].err));
    end

    rnd = 1'b1;
    run_sweeps(3);
    rnd = 1'b0;

    // Reset in the middle of the VOL conversion wait.
    cfg = '{6'b000000, 30, 12'h700, 1'b1, 1'b0,
            {12'h705, 12'h704, 12'h703, 12'h702, 12'h701, 12'h700}, 1'b0};
    begin
      int lim;
      lim = cyc + 3000;
      do step(); while (!(bus.strt_cnv && bus.chnnl == 3'd7) && cyc < lim);
      if (cyc >= lim) begin
        nvec++; nbad++;
        $display("FAIL vol_wait_timeout at cycle %0d", cyc);
      end
    end
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pots", dut_pots(), 72'h0);
    chk("rst_chnnl", 72'(bus.chnnl), 72'd1);
    chk("rst_strt", 72'(bus.strt_cnv), 72'd0);
    chk("rst_err", 72'(a2d_err), 72'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    exp_strt = cyc + GAP;
    stray_at = cyc + 2;
    run_sweeps(1);
    chk("post_rst_pots", dut_pots(), cfg.pots);
    chk("post_rst_err", 72'(a2d_err), 72'(cfg.err));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
